// File: rtl/regfile_mp.sv
// regfile_mp: 2R/2W register file with bypass, pending bits and sweep clear.
// Optional REGFILE_ZERO_REG0_EN makes register 0 a hard-wired zero.
module regfile_mp #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              We0,
    input  logic [ADDR_W-1:0] Waddr0,
    input  logic [DATA_W-1:0] Wdata0,
    input  logic              We1,
    input  logic [ADDR_W-1:0] Waddr1,
    input  logic [DATA_W-1:0] Wdata1,
    input  logic [ADDR_W-1:0] Rreg1,
    input  logic [ADDR_W-1:0] Rreg2,
    output logic [DATA_W-1:0] R1,
    output logic [DATA_W-1:0] R2,
    input  logic              Rsv_en,
    input  logic [ADDR_W-1:0] Rsv_addr,
    output logic              P1,
    output logic              P2,
    input  logic              Clear_req,
    output logic              Busy,
    output logic              Wr_drop
);

    localparam int DEPTH = 2 ** ADDR_W;

`ifdef REGFILE_ZERO_REG0_EN
    localparam bit ZERO_REG0 = 1'b1;
`else
    localparam bit ZERO_REG0 = 1'b0;
`endif

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   ptr;
    logic                busy_q;
    logic [DATA_W-1:0]   regs [DEPTH];
    logic [DEPTH-1:0]    pend;

    logic idle;
    logic we0_e;
    logic we1_e;
    logic rsv_e;

    assign idle = (state == IDLE);

    // Accesses to a hard-wired zero register never count as real requests
    assign we0_e = We0 && !(ZERO_REG0 && (Waddr0 == '0));
    assign we1_e = We1 && !(ZERO_REG0 && (Waddr1 == '0));
    assign rsv_e = Rsv_en && !(ZERO_REG0 && (Rsv_addr == '0));

    assign Wr_drop = !idle && (we0_e || we1_e || rsv_e);
    assign Busy    = busy_q;
    assign P1      = pend[Rreg1];
    assign P2      = pend[Rreg2];

    always_comb begin
        R1 = regs[Rreg1];
        if (idle && we0_e && (Waddr0 == Rreg1)) R1 = Wdata0;
        if (idle && we1_e && (Waddr1 == Rreg1)) R1 = Wdata1;
        if (ZERO_REG0 && (Rreg1 == '0)) R1 = '0;
    end

    always_comb begin
        R2 = regs[Rreg2];
        if (idle && we0_e && (Waddr0 == Rreg2)) R2 = Wdata0;
        if (idle && we1_e && (Waddr1 == Rreg2)) R2 = Wdata1;
        if (ZERO_REG0 && (Rreg2 == '0)) R2 = '0;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= IDLE;
            ptr    <= '0;
            busy_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (Clear_req) begin
                        state  <= CLEAR;
                        ptr    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == ADDR_W'(DEPTH - 1)) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            pend <= '0;
        end else if (idle) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (we1_e && (Waddr1 == ADDR_W'(i)))
                    regs[i] <= Wdata1;
                else if (we0_e && (Waddr0 == ADDR_W'(i)))
                    regs[i] <= Wdata0;
                // A reservation outranks a completing write to the same reg
                if (rsv_e && (Rsv_addr == ADDR_W'(i)))
                    pend[i] <= 1'b1;
                else if ((we1_e && (Waddr1 == ADDR_W'(i))) ||
                         (we0_e && (Waddr0 == ADDR_W'(i))))
                    pend[i] <= 1'b0;
            end
        end else begin
            regs[ptr] <= '0;
            pend[ptr] <= 1'b0;
        end
    end

endmodule
